// File: rtl/rr_hex_arbiter.sv
// Round-robin arbiter for eight request lines with a programmable hold period.
// Publishes the granted slot as one-hot, binary index and active-low 7-segment code.

module rr_hex_arbiter #(
   parameter int unsigned HOLD = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] req,
   output logic [7:0] grant,
   output logic       grant_valid,
   output logic [2:0] grant_idx,
   output logic [6:0] out_hex0
);

   localparam logic [0:0] StIdle    = 1'b0;
   localparam logic [0:0] StGrant   = 1'b1;
   localparam logic [7:0] CntReload = 8'(HOLD - 1);
   localparam logic [6:0] HexBlank  = 7'b1111111;

   function automatic logic [6:0] hex7(input logic [2:0] d);
      logic [6:0] seg;
      seg = HexBlank;
      unique case (d)
         3'd0: seg = 7'b1000000;
         3'd1: seg = 7'b1111001;
         3'd2: seg = 7'b0100100;
         3'd3: seg = 7'b0110000;
         3'd4: seg = 7'b0011001;
         3'd5: seg = 7'b0010010;
         3'd6: seg = 7'b0000010;
         3'd7: seg = 7'b1111000;
      endcase
      return seg;
   endfunction

   logic [0:0] r_state, w_state;
   logic [2:0] r_ptr,   w_ptr;
   logic [7:0] r_cnt,   w_cnt;
   logic [7:0] r_grant, w_grant;
   logic       r_valid, w_valid;
   logic [2:0] r_idx,   w_idx;
   logic [6:0] r_hex,   w_hex;

   logic [2:0]  w_base;
   logic [15:0] w_dbl;
   logic [15:0] w_dbl_sh;
   logic [7:0]  w_rot;
   logic [2:0]  w_off;
   logic        w_found;
   logic [2:0]  w_win;
   logic [2:0]  w_next_ptr;

   // While granting, the search for the next slot starts just past the holder,
   // so the holder itself is examined last.
   assign w_next_ptr = r_idx + 3'd1;
   assign w_base     = (r_state == StGrant) ? w_next_ptr : r_ptr;
   assign w_dbl      = {req, req};
   assign w_dbl_sh   = w_dbl >> w_base;
   assign w_rot      = w_dbl_sh[7:0];
   assign w_found    = |req;
   assign w_win      = w_base + w_off;

   always_comb begin
      w_off = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (w_rot[k]) w_off = 3'(k);
      end
   end

   always_comb begin
      w_state = r_state;
      w_ptr   = r_ptr;
      w_cnt   = r_cnt;
      w_grant = r_grant;
      w_valid = r_valid;
      w_idx   = r_idx;
      w_hex   = r_hex;

      unique case (r_state)
         StIdle: begin
            if (en && w_found) begin
               w_state = StGrant;
               w_grant = 8'b1 << w_win;
               w_valid = 1'b1;
               w_idx   = w_win;
               w_hex   = hex7(w_win);
               w_cnt   = CntReload;
            end
         end
         StGrant: begin
            if (!en) begin
               w_state = StIdle;
               w_ptr   = w_next_ptr;
               w_cnt   = 8'd0;
               w_grant = 8'd0;
               w_valid = 1'b0;
               w_hex   = HexBlank;
            end else if (!req[r_idx] || (r_cnt == 8'd0)) begin
               w_ptr = w_next_ptr;
               if (w_found) begin
                  w_grant = 8'b1 << w_win;
                  w_idx   = w_win;
                  w_hex   = hex7(w_win);
                  w_cnt   = CntReload;
               end else begin
                  w_state = StIdle;
                  w_cnt   = 8'd0;
                  w_grant = 8'd0;
                  w_valid = 1'b0;
                  w_hex   = HexBlank;
               end
            end else begin
               w_cnt = r_cnt - 8'd1;
            end
         end
         default: begin
            w_state = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_ptr   <= 3'd0;
         r_cnt   <= 8'd0;
         r_grant <= 8'd0;
         r_valid <= 1'b0;
         r_idx   <= 3'd0;
         r_hex   <= HexBlank;
      end else begin
         r_state <= w_state;
         r_ptr   <= w_ptr;
         r_cnt   <= w_cnt;
         r_grant <= w_grant;
         r_valid <= w_valid;
         r_idx   <= w_idx;
         r_hex   <= w_hex;
      end
   end

   assign grant       = r_grant;
   assign grant_valid = r_valid;
   assign grant_idx   = r_idx;
   assign out_hex0    = r_hex;

`ifndef SYNTHESIS
   a_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_grant));
   a_valid  : assert property (@(posedge clk) disable iff (!rst_n) r_valid == (r_grant != 8'd0));
`endif

endmodule

// File: tb/tb_rr_hex_arbiter.sv
// Randomised scoreboard bench: four arbiters with different hold periods share stimulus
// and are checked every cycle against a slot-level reference model.

module tb_rr_hex_arbiter;

   localparam int N = 4;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] req;

   logic [7:0] o_grant [N];
   logic       o_valid [N];
   logic [2:0] o_idx   [N];
   logic [6:0] o_hex   [N];

   int hold_of [N] = '{1, 2, 4, 256};
   logic [6:0] hex_tab [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

   rr_hex_arbiter #(.HOLD(1)) u_h1 (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .grant(o_grant[0]), .grant_valid(o_valid[0]), .grant_idx(o_idx[0]), .out_hex0(o_hex[0]));
   rr_hex_arbiter #(.HOLD(2)) u_h2 (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .grant(o_grant[1]), .grant_valid(o_valid[1]), .grant_idx(o_idx[1]), .out_hex0(o_hex[1]));
   rr_hex_arbiter #(.HOLD(4)) u_h4 (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .grant(o_grant[2]), .grant_valid(o_valid[2]), .grant_idx(o_idx[2]), .out_hex0(o_hex[2]));
   rr_hex_arbiter #(.HOLD(256)) u_h256 (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .grant(o_grant[3]), .grant_valid(o_valid[3]), .grant_idx(o_idx[3]), .out_hex0(o_hex[3]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int         inst;
      logic [7:0] grant;
      logic       valid;
      logic [2:0] idx;
      logic [6:0] hex;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: who holds the display, how many cycles of its slot remain,
   // and where the next search begins.
   bit m_busy [N];
   int m_idx  [N];
   int m_left [N];
   int m_ptr  [N];

   task automatic chk(input string nm, input int inst, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s hold=%0d t=%0t: got %h want %h", nm, hold_of[inst], $time, act, exp);
      end
   endtask

   function automatic int pick(input int base, input logic [7:0] r);
      for (int i = 0; i < 8; i++) begin
         if (r[(base + i) % 8]) return (base + i) % 8;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_busy[k] = 1'b0;
         m_idx[k]  = 0;
         m_left[k] = 0;
         m_ptr[k]  = 0;
      end
   endtask

   task automatic model_edge(input logic e, input logic [7:0] r);
      int w;
      exp_t x;
      for (int k = 0; k < N; k++) begin
         if (!m_busy[k]) begin
            w = e ? pick(m_ptr[k], r) : -1;
            if (w >= 0) begin
               m_busy[k] = 1'b1;
               m_idx[k]  = w;
               m_left[k] = hold_of[k];
            end
         end else if (!e) begin
            m_busy[k] = 1'b0;
            m_ptr[k]  = (m_idx[k] + 1) % 8;
         end else if (!r[m_idx[k]] || m_left[k] == 1) begin
            m_ptr[k] = (m_idx[k] + 1) % 8;
            w = pick(m_ptr[k], r);
            if (w >= 0) begin
               m_idx[k]  = w;
               m_left[k] = hold_of[k];
            end else begin
               m_busy[k] = 1'b0;
            end
         end else begin
            m_left[k]--;
         end
         x.inst  = k;
         x.valid = m_busy[k];
         x.grant = m_busy[k] ? (8'b1 << m_idx[k]) : 8'd0;
         x.idx   = 3'(m_idx[k]);
         x.hex   = m_busy[k] ? hex_tab[m_idx[k]] : 7'b1111111;
         sb.push_back(x);
      end
   endtask

   task automatic drive(input logic e, input logic [7:0] r);
      en  = e;
      req = r;
      model_edge(e, r);
   endtask

   task automatic step(input logic e, input logic [7:0] r);
      @(negedge clk);
      drive(e, r);
   endtask

   task automatic check_reset_outputs();
      for (int k = 0; k < N; k++) begin
         chk("rst_grant", k, 32'(o_grant[k]), 32'h0);
         chk("rst_valid", k, 32'(o_valid[k]), 32'h0);
         chk("rst_idx",   k, 32'(o_idx[k]),   32'h0);
         chk("rst_hex",   k, 32'(o_hex[k]),   32'h7f);
      end
   endtask

   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         while (sb.size() > 0) begin
            x = sb.pop_front();
            chk("grant",     x.inst, 32'(o_grant[x.inst]), 32'(x.grant));
            chk("valid",     x.inst, 32'(o_valid[x.inst]), 32'(x.valid));
            chk("grant_idx", x.inst, 32'(o_idx[x.inst]),   32'(x.idx));
            chk("hex",       x.inst, 32'(o_hex[x.inst]),   32'(x.hex));
         end
      end
   end

   initial begin
      logic [7:0] r;
      rst_n = 1'b0;
      en    = 1'b1;
      req   = 8'hFF;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs();

      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 8'hFF);

      for (int i = 0; i < 20; i++) step(1'b1, 8'b1000_0001);
      for (int i = 0; i < 20; i++) step(1'b1, 8'hFF);
      // Early release of a mid-slot holder.
      step(1'b1, 8'b0100_1000);
      step(1'b1, 8'b0100_0000);
      for (int i = 0; i < 6; i++) step(1'b1, 8'b0100_0000);
      // Abort and re-enable.
      step(1'b1, 8'b0000_0100);
      step(1'b1, 8'b0000_0100);
      step(1'b0, 8'b0000_0100);
      step(1'b1, 8'hFF);
      for (int i = 0; i < 4; i++) step(1'b1, 8'hFF);
      // Single requester leaving, then idle.
      for (int i = 0; i < 4; i++) step(1'b1, 8'b0001_0000);
      for (int i = 0; i < 4; i++) step(1'b1, 8'h00);

      for (int i = 0; i < 600; i++) begin
         r = 8'($urandom) & 8'($urandom);
         if ($urandom_range(0, 7) == 0) r = 8'd1 << $urandom_range(0, 7);
         step($urandom_range(0, 11) != 0, r);
      end

      // Asynchronous reset in the middle of a grant.
      for (int i = 0; i < 3; i++) step(1'b1, 8'hFF);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 8'b0010_0000);

      for (int i = 0; i < 300; i++) begin
         r = 8'($urandom) & 8'($urandom) & 8'($urandom);
         step($urandom_range(0, 15) != 0, r);
      end
      for (int i = 0; i < 3; i++) step(1'b1, 8'h00);

      @(posedge clk);
      #3;
      chk("sb_drained", 0, 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
